// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two requester handshakes and the shared-ALU connection of
//   alu_arbiter.
//   Requester i (i = 0,1):
//     reqi/opi/ai/bi            request level and operands (master -> slave)
//     gnti/donei                one-cycle pulses            (slave -> master)
//     resulti/zeroi/erri        last completion of requester i
//   Shared ALU:
//     alu_op/alu_a/alu_b        registered drive to the ALU (slave -> master)
//     alu_result/alu_zero       combinational ALU outputs   (master -> slave)
//   busy                        arbiter is in its EXEC cycle
//   Modports: slave = arbiter side, master = requester/ALU side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
);
   logic             req0;
   logic [OPW-1:0]   op0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             gnt0;
   logic             done0;
   logic [WIDTH-1:0] result0;
   logic             zero0;
   logic             err0;

   logic             req1;
   logic [OPW-1:0]   op1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt1;
   logic             done1;
   logic [WIDTH-1:0] result1;
   logic             zero1;
   logic             err1;

   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             busy;

   modport slave (
      input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
      output gnt0, done0, result0, zero0, err0,
      output gnt1, done1, result1, zero1, err1,
      output alu_op, alu_a, alu_b, busy
   );

   modport master (
      output req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
      input  gnt0, done0, result0, zero0, err0,
      input  gnt1, done1, result1, zero1, err1,
      input  alu_op, alu_a, alu_b, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   arbitration. A grant latches the winner's op/operands into the ALU drive
//   registers; the following cycle (EXEC) the ALU output is captured into the
//   winner's result/zero/err registers with a one-cycle done pulse. One op is
//   completed every two cycles at best.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    alu_arbiter_if.slave (requester handshakes + shared ALU)
//   Optional (macro ALU_ARBITER_PERF_EN):
//     grant_cnt0/grant_cnt1  grants per requester (wrapping)
//     conflict_cnt           IDLE edges with both requests high (wrapping)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic        clk,
   input  logic        reset,
   alu_arbiter_if.slave bus
`ifdef ALU_ARBITER_PERF_EN
   ,
   output logic [31:0] grant_cnt0,
   output logic [31:0] grant_cnt1,
   output logic [31:0] conflict_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t           state_reg, state_next;
   logic             rr_ptr_reg, rr_ptr_next;     // preferred requester on a tie
   logic             owner_reg, owner_next;       // requester being served
   logic             illegal_reg, illegal_next;   // served op was not a legal op
   logic [OPW-1:0]   alu_op_reg, alu_op_next;
   logic [WIDTH-1:0] alu_a_reg, alu_a_next;
   logic [WIDTH-1:0] alu_b_reg, alu_b_next;
   logic             gnt0_reg, gnt0_next, gnt1_reg, gnt1_next;
   logic             done0_reg, done0_next, done1_reg, done1_next;
   logic [WIDTH-1:0] result0_reg, result0_next, result1_reg, result1_next;
   logic             zero0_reg, zero0_next, zero1_reg, zero1_next;
   logic             err0_reg, err0_next, err1_reg, err1_next;
   logic             busy_reg, busy_next;

   logic             pick1;
   logic             legal;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   function automatic logic op_legal(input logic [OPW-1:0] op);
      return (op == OPW'(0)) || (op == OPW'(1)) || (op == OPW'(2)) ||
             (op == OPW'(6)) || (op == OPW'(7));
   endfunction

   always_comb begin
      state_next   = state_reg;
      rr_ptr_next  = rr_ptr_reg;
      owner_next   = owner_reg;
      illegal_next = illegal_reg;
      alu_op_next  = alu_op_reg;
      alu_a_next   = alu_a_reg;
      alu_b_next   = alu_b_reg;
      gnt0_next    = 1'b0;
      gnt1_next    = 1'b0;
      done0_next   = 1'b0;
      done1_next   = 1'b0;
      result0_next = result0_reg;
      result1_next = result1_reg;
      zero0_next   = zero0_reg;
      zero1_next   = zero1_reg;
      err0_next    = err0_reg;
      err1_next    = err1_reg;
      busy_next    = busy_reg;
      pick1        = 1'b0;
      legal        = 1'b0;
      sel_op       = '0;
      sel_a        = '0;
      sel_b        = '0;

      case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // Requester 1 wins when alone, or on a tie when it is preferred.
               pick1  = bus.req1 & (~bus.req0 | rr_ptr_reg);
               sel_op = pick1 ? bus.op1 : bus.op0;
               sel_a  = pick1 ? bus.a1  : bus.a0;
               sel_b  = pick1 ? bus.b1  : bus.b0;
               legal  = op_legal(sel_op);
               // Illegal ops still occupy EXEC but present an all-zero ALU drive.
               alu_op_next  = legal ? sel_op : '0;
               alu_a_next   = legal ? sel_a  : '0;
               alu_b_next   = legal ? sel_b  : '0;
               owner_next   = pick1;
               illegal_next = ~legal;
               rr_ptr_next  = ~pick1;
               gnt0_next    = ~pick1;
               gnt1_next    = pick1;
               busy_next    = 1'b1;
               state_next   = EXEC;
            end
         end
         EXEC: begin
            if (owner_reg) begin
               result1_next = illegal_reg ? '0 : bus.alu_result;
               zero1_next   = ~illegal_reg & bus.alu_zero;
               err1_next    = illegal_reg;
               done1_next   = 1'b1;
            end else begin
               result0_next = illegal_reg ? '0 : bus.alu_result;
               zero0_next   = ~illegal_reg & bus.alu_zero;
               err0_next    = illegal_reg;
               done0_next   = 1'b1;
            end
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         rr_ptr_reg  <= 1'b0;
         owner_reg   <= 1'b0;
         illegal_reg <= 1'b0;
         alu_op_reg  <= '0;
         alu_a_reg   <= '0;
         alu_b_reg   <= '0;
         gnt0_reg    <= 1'b0;
         gnt1_reg    <= 1'b0;
         done0_reg   <= 1'b0;
         done1_reg   <= 1'b0;
         result0_reg <= '0;
         result1_reg <= '0;
         zero0_reg   <= 1'b0;
         zero1_reg   <= 1'b0;
         err0_reg    <= 1'b0;
         err1_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rr_ptr_reg  <= rr_ptr_next;
         owner_reg   <= owner_next;
         illegal_reg <= illegal_next;
         alu_op_reg  <= alu_op_next;
         alu_a_reg   <= alu_a_next;
         alu_b_reg   <= alu_b_next;
         gnt0_reg    <= gnt0_next;
         gnt1_reg    <= gnt1_next;
         done0_reg   <= done0_next;
         done1_reg   <= done1_next;
         result0_reg <= result0_next;
         result1_reg <= result1_next;
         zero0_reg   <= zero0_next;
         zero1_reg   <= zero1_next;
         err0_reg    <= err0_next;
         err1_reg    <= err1_next;
         busy_reg    <= busy_next;
      end
   end

   assign bus.gnt0    = gnt0_reg;
   assign bus.gnt1    = gnt1_reg;
   assign bus.done0   = done0_reg;
   assign bus.done1   = done1_reg;
   assign bus.result0 = result0_reg;
   assign bus.result1 = result1_reg;
   assign bus.zero0   = zero0_reg;
   assign bus.zero1   = zero1_reg;
   assign bus.err0    = err0_reg;
   assign bus.err1    = err1_reg;
   assign bus.alu_op  = alu_op_reg;
   assign bus.alu_a   = alu_a_reg;
   assign bus.alu_b   = alu_b_reg;
   assign bus.busy    = busy_reg;

`ifdef ALU_ARBITER_PERF_EN
   logic [31:0] grant_cnt0_reg, grant_cnt1_reg, conflict_cnt_reg;
   logic        conflict;

   assign conflict = (state_reg == IDLE) & bus.req0 & bus.req1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt0_reg   <= '0;
         grant_cnt1_reg   <= '0;
         conflict_cnt_reg <= '0;
      end else begin
         if (gnt0_next) grant_cnt0_reg   <= grant_cnt0_reg + 32'd1;
         if (gnt1_next) grant_cnt1_reg   <= grant_cnt1_reg + 32'd1;
         if (conflict)  conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
   end

   assign grant_cnt0   = grant_cnt0_reg;
   assign grant_cnt1   = grant_cnt1_reg;
   assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Provides a behavioural shared ALU,
//   drives both requesters and compares against a transaction-level model
//   (expected owner from round-robin preference, expected per-requester
//   result/zero/err from the op semantics). Counter checks are compiled in
//   when ALU_ARBITER_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int WIDTH = 32;
   localparam int OPW   = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

`ifdef ALU_ARBITER_PERF_EN
   logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ALU_ARBITER_PERF_EN
      ,
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1),
      .conflict_cnt (conflict_cnt)
`endif
   );

   // Op semantics: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed).
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd6: return a - b;
         4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Shared combinational ALU seen by the DUT.
   assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
   assign bus.alu_zero   = (bus.alu_result == 32'd0);

   int          vecs = 0;
   int          errs = 0;
   bit          m_rr;
   logic [31:0] m_res [2];
   bit          m_zero[2];
   bit          m_err [2];
   logic [3:0]  legal_tab[5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};

   function automatic bit is_legal(input logic [3:0] op);
      return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
   endfunction

   task automatic model_reset();
      m_rr = 1'b0;
      for (int r = 0; r < 2; r++) begin
         m_res[r] = '0; m_zero[r] = 1'b0; m_err[r] = 1'b0;
      end
   endtask

   task automatic model_complete(input int who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (is_legal(op)) begin
         m_res[who]  = alu_fn(op, a, b);
         m_zero[who] = (m_res[who] == 32'd0);
         m_err[who]  = 1'b0;
      end else begin
         m_res[who] = '0; m_zero[who] = 1'b0; m_err[who] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input bit en, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.req0 = en; bus.op0 = op; bus.a0 = a; bus.b0 = b;
      end else begin
         bus.req1 = en; bus.op1 = op; bus.a1 = a; bus.b1 = b;
      end
   endtask

   task automatic test_reset();
      set_req(0, 1'b0, 4'd0, '0, '0);
      set_req(1, 1'b0, 4'd0, '0, '0);
      reset = 1'b1;
      tick(); tick();
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.zero0, bus.zero1, bus.err0, bus.err1, bus.busy} !== 9'd0) begin
         errs++; $display("FAIL reset_flags: got %b want 0", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.zero0, bus.zero1, bus.err0, bus.err1, bus.busy});
      end
      vecs++;
      if ({bus.result0, bus.result1, bus.alu_op, bus.alu_a, bus.alu_b} !== 132'd0) begin
         errs++; $display("FAIL reset_data: got r0=%h r1=%h op=%h a=%h b=%h want all 0", bus.result0, bus.result1, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      reset = 1'b0;
      model_reset();
      $display("txn reset");
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 4'd2, 32'd5, 32'd7);
      tick();
      vecs++;
      if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
         errs++; $display("FAIL single_gnt: got gnt0/gnt1/busy=%b want 101", {bus.gnt0, bus.gnt1, bus.busy});
      end
      vecs++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {4'd2, 32'd5, 32'd7}) begin
         errs++; $display("FAIL single_alu: got op=%h a=%h b=%h want 2/5/7", bus.alu_op, bus.alu_a, bus.alu_b);
      end
      set_req(0, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if ({bus.done0, bus.done1, bus.gnt0, bus.busy} !== 4'b1000) begin
         errs++; $display("FAIL single_done: got done0/done1/gnt0/busy=%b want 1000", {bus.done0, bus.done1, bus.gnt0, bus.busy});
      end
      vecs++;
      if ({bus.result0, bus.zero0, bus.err0} !== {32'd12, 1'b0, 1'b0}) begin
         errs++; $display("FAIL single_result: got %h/%b/%b want 0000000c/0/0", bus.result0, bus.zero0, bus.err0);
      end
      tick();
      vecs++;
      if ({bus.done0, bus.gnt1, bus.done1} !== 3'b000) begin
         errs++; $display("FAIL single_quiet: got done0/gnt1/done1=%b want 000", {bus.done0, bus.gnt1, bus.done1});
      end
      model_complete(0, 4'd2, 32'd5, 32'd7);
      m_rr = 1'b1;
      $display("txn single owner 0 result %h", bus.result0);
   endtask

   task automatic test_contention();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      set_req(0, 1'b1, 4'd0, 32'h0000_F0F0, 32'h0000_0FF0);
      set_req(1, 1'b1, 4'd1, 32'h1, 32'h2);
      for (int k = 0; k < 4; k++) begin
         int own;
         own = m_rr ? 1 : 0;
         tick();
         vecs++;
         if ({bus.gnt1, bus.gnt0} !== (own == 1 ? 2'b10 : 2'b01)) begin
            errs++; $display("FAIL contention_gnt[%0d]: got gnt1/gnt0=%b want owner %0d", k, {bus.gnt1, bus.gnt0}, own);
         end
         m_rr = (own == 0);
         if (k == 3) begin
            set_req(0, 1'b0, 4'd0, '0, '0);
            set_req(1, 1'b0, 4'd0, '0, '0);
         end
         tick();
         if (own == 0) model_complete(0, 4'd0, 32'h0000_F0F0, 32'h0000_0FF0);
         else          model_complete(1, 4'd1, 32'h1, 32'h2);
         vecs++;
         if ({bus.done1, bus.done0} !== (own == 1 ? 2'b10 : 2'b01) || bus.result0 !== m_res[0] || bus.result1 !== m_res[1]) begin
            errs++; $display("FAIL contention_done[%0d]: got done=%b r0=%h r1=%h want owner %0d r0=%h r1=%h",
                             k, {bus.done1, bus.done0}, bus.result0, bus.result1, own, m_res[0], m_res[1]);
         end
         $display("txn contention %0d owner %0d", k, own);
      end
      vecs++;
      if (bus.result0 !== 32'h0000_00F0 || bus.result1 !== 32'h3) begin
         errs++; $display("FAIL contention_final: got r0=%h r1=%h want 000000f0/00000003", bus.result0, bus.result1);
      end
   endtask

   task automatic test_hold();
      set_req(0, 1'b1, 4'd6, 32'd9, 32'd9);
      tick();
      set_req(0, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if ({bus.done0, bus.result0, bus.zero0, bus.err0} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
         errs++; $display("FAIL hold_sub: got done0=%b r0=%h z0=%b e0=%b want 1/0/1/0", bus.done0, bus.result0, bus.zero0, bus.err0);
      end
      set_req(1, 1'b1, 4'd2, 32'd3, 32'd4);
      tick();
      set_req(1, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if ({bus.done1, bus.result1, bus.result0, bus.zero0, bus.err0} !== {1'b1, 32'd7, 32'd0, 1'b1, 1'b0}) begin
         errs++; $display("FAIL hold_indep: got done1=%b r1=%h r0=%h z0=%b e0=%b want 1/7/0/1/0",
                          bus.done1, bus.result1, bus.result0, bus.zero0, bus.err0);
      end
      model_complete(0, 4'd6, 32'd9, 32'd9);
      model_complete(1, 4'd2, 32'd3, 32'd4);
      m_rr = 1'b0;
      $display("txn hold r0=%h r1=%h", bus.result0, bus.result1);
   endtask

   task automatic test_illegal();
      set_req(1, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      vecs++;
      if ({bus.gnt1, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 68'd0}) begin
         errs++; $display("FAIL illegal_alu: got gnt1=%b op=%h a=%h b=%h want 1/0/0/0", bus.gnt1, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      set_req(1, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if ({bus.done1, bus.result1, bus.zero1, bus.err1} !== {1'b1, 32'd0, 1'b0, 1'b1}) begin
         errs++; $display("FAIL illegal_done: got done1=%b r1=%h z1=%b e1=%b want 1/0/0/1", bus.done1, bus.result1, bus.zero1, bus.err1);
      end
      set_req(1, 1'b1, 4'd2, 32'd1, 32'd1);
      tick();
      set_req(1, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if ({bus.done1, bus.result1, bus.err1} !== {1'b1, 32'd2, 1'b0}) begin
         errs++; $display("FAIL illegal_clear: got done1=%b r1=%h e1=%b want 1/2/0", bus.done1, bus.result1, bus.err1);
      end
      model_complete(1, 4'd2, 32'd1, 32'd1);
      m_rr = 1'b0;
      $display("txn illegal then legal r1=%h", bus.result1);
   endtask

   task automatic test_reset_mid();
      set_req(0, 1'b1, 4'd2, 32'd3, 32'd4);
      tick();
      set_req(0, 1'b0, 4'd0, '0, '0);
      tick();
      vecs++;
      if (bus.result0 !== 32'd7) begin
         errs++; $display("FAIL resetmid_pre: got r0=%h want 7", bus.result0);
      end
      set_req(0, 1'b1, 4'd2, 32'd10, 32'd20);
      tick();
      set_req(0, 1'b0, 4'd0, '0, '0);
      #2 reset = 1'b1;
      #1;
      vecs++;
      if ({bus.busy, bus.gnt0, bus.result0, bus.alu_op, bus.alu_a, bus.alu_b} !== 102'd0) begin
         errs++; $display("FAIL resetmid_async: got busy=%b gnt0=%b r0=%h op=%h a=%h b=%h want 0",
                          bus.busy, bus.gnt0, bus.result0, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      tick();
      vecs++;
      if ({bus.done0, bus.busy, bus.result0} !== 34'd0) begin
         errs++; $display("FAIL resetmid_nodone: got done0=%b busy=%b r0=%h want 0", bus.done0, bus.busy, bus.result0);
      end
      reset = 1'b0;
      model_reset();
      set_req(0, 1'b1, 4'd2, 32'd1, 32'd2);
      set_req(1, 1'b1, 4'd2, 32'd5, 32'd6);
      tick();
      vecs++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
         errs++; $display("FAIL resetmid_rr: got gnt1/gnt0=%b want 01", {bus.gnt1, bus.gnt0});
      end
      set_req(0, 1'b0, 4'd0, '0, '0);
      set_req(1, 1'b0, 4'd0, '0, '0);
      tick();
      model_complete(0, 4'd2, 32'd1, 32'd2);
      m_rr = 1'b1;
      vecs++;
      if ({bus.done0, bus.result0} !== {1'b1, m_res[0]}) begin
         errs++; $display("FAIL resetmid_after: got done0=%b r0=%h want 1/%h", bus.done0, bus.result0, m_res[0]);
      end
      $display("txn reset mid-op, recovered owner 0");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         bit          r0, r1;
         logic [3:0]  op[2];
         logic [31:0] a[2], b[2];
         int          own;
         bit          lg;
         for (int r = 0; r < 2; r++) begin
            op[r] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_tab[$urandom_range(0, 4)];
            a[r]  = $urandom;
            b[r]  = ($urandom_range(0, 3) == 0) ? a[r] : $urandom;
         end
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         set_req(0, r0, op[0], a[0], b[0]);
         set_req(1, r1, op[1], a[1], b[1]);
         tick();
         if (!r0 && !r1) begin
            vecs++;
            if ({bus.gnt1, bus.gnt0, bus.busy} !== 3'b000) begin
               errs++; $display("FAIL rand_idle[%0d]: got gnt1/gnt0/busy=%b want 000", i, {bus.gnt1, bus.gnt0, bus.busy});
            end
            $display("txn rand %0d idle", i);
            continue;
         end
         own = (r0 && r1) ? (m_rr ? 1 : 0) : (r1 ? 1 : 0);
         lg  = is_legal(op[own]);
         vecs++;
         if ({bus.gnt1, bus.gnt0, bus.busy} !== (own == 1 ? 3'b101 : 3'b011)) begin
            errs++; $display("FAIL rand_gnt[%0d]: got gnt1/gnt0/busy=%b want owner %0d", i, {bus.gnt1, bus.gnt0, bus.busy}, own);
         end
         vecs++;
         if ({bus.alu_op, bus.alu_a, bus.alu_b} !== (lg ? {op[own], a[own], b[own]} : 68'd0)) begin
            errs++; $display("FAIL rand_alu[%0d]: got op=%h a=%h b=%h req op=%h a=%h b=%h legal=%0d",
                             i, bus.alu_op, bus.alu_a, bus.alu_b, op[own], a[own], b[own], lg);
         end
         m_rr = (own == 0);
         set_req(0, 1'b0, op[0], a[0], b[0]);
         set_req(1, 1'b0, op[1], a[1], b[1]);
         tick();
         model_complete(own, op[own], a[own], b[own]);
         vecs++;
         if ({bus.done1, bus.done0, bus.busy} !== (own == 1 ? 3'b100 : 3'b010)) begin
            errs++; $display("FAIL rand_done[%0d]: got done1/done0/busy=%b want owner %0d", i, {bus.done1, bus.done0, bus.busy}, own);
         end
         vecs++;
         if (bus.result0 !== m_res[0] || bus.zero0 !== m_zero[0] || bus.err0 !== m_err[0]) begin
            errs++; $display("FAIL rand_req0[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.result0, bus.zero0, bus.err0, m_res[0], m_zero[0], m_err[0]);
         end
         vecs++;
         if (bus.result1 !== m_res[1] || bus.zero1 !== m_zero[1] || bus.err1 !== m_err[1]) begin
            errs++; $display("FAIL rand_req1[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.result1, bus.zero1, bus.err1, m_res[1], m_zero[1], m_err[1]);
         end
         $display("txn rand %0d req=%b%b owner %0d op %h result %h err %0d", i, r1, r0, own, op[own], m_res[own], m_err[own]);
      end
   endtask

`ifdef ALU_ARBITER_PERF_EN
   task automatic test_perf();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      set_req(0, 1'b1, 4'd2, 32'd1, 32'd1);
      set_req(1, 1'b1, 4'd2, 32'd2, 32'd2);
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 5) set_req(0, 1'b0, 4'd0, '0, '0);
         if (k == 5) set_req(1, 1'b0, 4'd0, '0, '0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         set_req(1, 1'b1, 4'd1, 32'd4, 32'd8);
         tick();
         set_req(1, 1'b0, 4'd0, '0, '0);
         tick();
      end
      vecs++;
      if ({grant_cnt0, grant_cnt1, conflict_cnt} !== {32'd3, 32'd5, 32'd6}) begin
         errs++; $display("FAIL perf_counts: got g0=%0d g1=%0d c=%0d want 3/5/6", grant_cnt0, grant_cnt1, conflict_cnt);
      end
      $display("txn perf g0=%0d g1=%0d c=%0d", grant_cnt0, grant_cnt1, conflict_cnt);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_hold();
      test_illegal();
      test_reset_mid();
      test_random();
`ifdef ALU_ARBITER_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
